// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned WIDTH x WIDTH shift-and-add multiplier.
// The partial-product addition is done by an external ripple adder reached
// through the add_* ports; this block owns the operand registers and the
// shift/accumulate sequencing.
//
// Handshake: start is sampled only while idle (busy=0, done=0). The accepting
// edge captures mcand/mplier and raises busy. busy stays high for WIDTH
// cycles, then done pulses for exactly one cycle with product final. Requests
// seen while busy or done are dropped, not queued. product holds its value
// until the next accepted start.
module shift_add_multiplier #(
  parameter int WIDTH = 15,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_c,
  input  logic [WIDTH-1:0]   add_s,
  input  logic               add_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic [WIDTH-1:0] m;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   csum;
  logic             last_iter;

  // Carry/sum to shift in: adder result when the current multiplier bit is
  // set, otherwise the high half unchanged.
  assign csum      = p_lo[0] ? {add_cout, add_s} : {1'b0, p_hi};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  assign add_a   = p_hi;
  assign add_b   = m;
  assign add_c   = 1'b0;
  assign product = {p_hi, p_lo};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture and one shift-accumulate iteration per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_hi <= '0;
      p_lo <= '0;
      m    <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m    <= mcand;
            p_lo <= mplier;
            p_hi <= '0;
            cnt  <= '0;
          end
        end
        RUN: begin
          // 31-bit {carry, sum, p_lo} shifted right by one, LSB dropped.
          p_hi <= csum[WIDTH:1];
          p_lo <= {csum[0], p_lo[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
